conv_window_ctrl: RTL and testbench

Parametrised sequencer for the convolution engine. It tracks the raster position of an incoming pixel stream and drives the line-buffer shift enable. It flags each position where a complete KxK window, aligned to the configured stride, is available, and reports the output-map coordinate of that window. It also selects the ping-pong result bank and swaps it at every frame boundary, with downstream backpressure.

---
 rtl/conv_window_ctrl.sv | 153 +++++++++++++++
 tb/tb_conv_window_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_ctrl.sv
// Window sequencer for the convolution engine: tracks the raster position of
// the incoming pixel stream, flags stride-aligned KxK windows, presents their
// output-map coordinates with a valid/ready handshake and flips the ping-pong
// result bank once per frame.
//
// state | meaning
// IDLE  | waiting for the first pixel of a frame
// RUN   | accepting pixels of the current frame
// DRAIN | all pixels taken, waiting for the last window to be consumed
// DONE  | one-cycle frame_done, result bank swaps on exit
module conv_window_ctrl #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  localparam int OUT_W = (IMG_W - K) / STRIDE + 1,
  localparam int OUT_H = (IMG_H - K) / STRIDE + 1,
  localparam int XW    = (OUT_W > 1) ? $clog2(OUT_W) : 1,
  localparam int YW    = (OUT_H > 1) ? $clog2(OUT_H) : 1,
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_in,
  input  logic          ready_in,
  output logic          ready_out,
  output logic          oe,
  output logic          valid_out,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          pp_sel,
  output logic          frame_done,
  output logic          busy
);

  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(K - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(OUT_W - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(OUT_H - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(STRIDE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] col_phase, row_phase;
  logic          col_last, row_last, last_pix;
  logic          hit, consume;

  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  assign last_pix = col_last && row_last;

  // DRAIN/DONE close the input so the next frame cannot overlap the swap
  assign ready_out  = (!valid_out || ready_in) && (state == IDLE || state == RUN);
  assign oe         = valid_in && ready_out;
  assign consume    = valid_out && ready_in;
  assign hit        = oe && (col >= COL_WIN) && (row >= ROW_WIN)
                      && (col_phase == '0) && (row_phase == '0);
  assign busy       = (state == RUN) || (state == DRAIN);
  assign frame_done = (state == DONE);

  // Raster position of the next pixel, advanced only on accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (oe) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Stride phases count from the first full-window column/row, wrapping at STRIDE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_phase <= '0;
      row_phase <= '0;
    end else if (oe) begin
      if (col_last || col < COL_WIN) begin
        col_phase <= '0;
      end else begin
        col_phase <= (col_phase == PH_LAST) ? '0 : col_phase + PW'(1);
      end
      if (col_last) begin
        if (row_last || row < ROW_WIN) begin
          row_phase <= '0;
        end else begin
          row_phase <= (row_phase == PH_LAST) ? '0 : row_phase + PW'(1);
        end
      end
    end
  end

  // Window result register; coordinates step to the next window on consume
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
    end else begin
      if (hit) begin
        valid_out <= 1'b1;
      end else if (ready_in) begin
        valid_out <= 1'b0;
      end
      if (consume) begin
        if (out_x == X_LAST) begin
          out_x <= '0;
          out_y <= (out_y == Y_LAST) ? '0 : out_y + YW'(1);
        end else begin
          out_x <= out_x + XW'(1);
        end
      end
    end
  end

  // Frame state register and result bank select
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      pp_sel <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == DONE) begin
        pp_sel <= ~pp_sel;
      end
    end
  end

  // Frame sequencing
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (oe) state_nxt = last_pix ? DRAIN : RUN;
      RUN:   if (oe && last_pix) state_nxt = DRAIN;
      DRAIN: if (!valid_out || ready_in) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
module tb_conv_window_ctrl;

  localparam int W  = 6, H = 6, KK = 3, S = 1, OW = 4, OH = 4;
  localparam int W2 = 7, H2 = 7, S2 = 2, OW2 = 3, OH2 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       valid_in, ready_in, ready_out, oe, valid_out;
  logic [1:0] out_x, out_y;
  logic [2:0] col, row;
  logic       pp_sel, frame_done, busy;

  logic       b_valid_in, b_ready_in, b_ready_out, b_oe, b_valid_out;
  logic [1:0] b_out_x, b_out_y;
  logic [2:0] b_col, b_row;
  logic       b_pp_sel, b_frame_done, b_busy;

  conv_window_ctrl #(.IMG_W(W), .IMG_H(H), .K(KK), .STRIDE(S)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .ready_out(ready_out), .oe(oe), .valid_out(valid_out),
    .out_x(out_x), .out_y(out_y), .col(col), .row(row),
    .pp_sel(pp_sel), .frame_done(frame_done), .busy(busy)
  );

  conv_window_ctrl #(.IMG_W(W2), .IMG_H(H2), .K(KK), .STRIDE(S2)) dut_s2 (
    .clk(clk), .reset(reset), .valid_in(b_valid_in), .ready_in(b_ready_in),
    .ready_out(b_ready_out), .oe(b_oe), .valid_out(b_valid_out),
    .out_x(b_out_x), .out_y(b_out_y), .col(b_col), .row(b_row),
    .pp_sel(b_pp_sel), .frame_done(b_frame_done), .busy(b_busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Window test on pixel index p of a w-wide frame; returns output coordinate
  function automatic bit win_at(input int p, input int w, input int k, input int s,
                                output int ox, output int oy);
    int c, r;
    c  = p % w;
    r  = p / w;
    ox = (c - k + 1) / s;
    oy = (r - k + 1) / s;
    return (c >= k - 1) && (r >= k - 1) && ((c - k + 1) % s == 0) && ((r - k + 1) % s == 0);
  endfunction

  // Reference model state for the main instance
  int pix, wc, frames;
  int q_x[$], q_y[$];
  bit m_run, m_drain, m_done, m_pp;

  task automatic model_clear();
    pix = 0; wc = 0;
    q_x.delete(); q_y.delete();
    m_run = 0; m_drain = 0; m_done = 0; m_pp = 0;
  endtask

  function automatic bit model_ready();
    return (q_x.size() == 0 || ready_in) && !m_drain && !m_done;
  endfunction

  task automatic check_outputs();
    bit mr;
    mr = model_ready();
    check_val("ready_out", int'(ready_out), int'(mr));
    check_val("oe", int'(oe), int'(valid_in && mr));
    check_val("valid_out", int'(valid_out), int'(q_x.size() > 0));
    if (q_x.size() > 0) begin
      check_val("out_x", int'(out_x), q_x[0]);
      check_val("out_y", int'(out_y), q_y[0]);
    end
    check_val("col", int'(col), pix % W);
    check_val("row", int'(row), pix / W);
    check_val("busy", int'(busy), int'(m_run || m_drain));
    check_val("frame_done", int'(frame_done), int'(m_done));
    check_val("pp_sel", int'(pp_sel), int'(m_pp));
  endtask

  task automatic model_step();
    bit mr, acc, cons, was_done, drain_end;
    int ox, oy;
    mr        = model_ready();
    acc       = valid_in && mr;
    cons      = (q_x.size() > 0) && ready_in;
    was_done  = m_done;
    drain_end = m_drain && (q_x.size() == 0 || ready_in);
    if (was_done) begin
      check_val("win_count", wc, OW * OH);
      m_done = 0; m_pp = !m_pp; wc = 0; frames++;
    end else if (drain_end) begin
      m_drain = 0; m_done = 1;
    end
    if (cons) begin
      void'(q_x.pop_front()); void'(q_y.pop_front());
      wc++;
    end
    if (acc) begin
      if (win_at(pix, W, KK, S, ox, oy)) begin
        q_x.push_back(ox); q_y.push_back(oy);
      end
      if (pix == W * H - 1) begin
        m_run = 0; m_drain = 1; pix = 0;
      end else begin
        m_run = 1; pix++;
      end
    end
  endtask

  // One clock of the main instance, entered and left at the falling edge
  task automatic cycle(input bit v, input bit r);
    valid_in = v; ready_in = r;
    #1;
    check_outputs();
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
    #2;
    check_val("rst_col", int'(col), 0);
    check_val("rst_row", int'(row), 0);
    check_val("rst_out_x", int'(out_x), 0);
    check_val("rst_out_y", int'(out_y), 0);
    check_val("rst_valid_out", int'(valid_out), 0);
    check_val("rst_pp_sel", int'(pp_sel), 0);
    check_val("rst_frame_done", int'(frame_done), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_ready_out", int'(ready_out), 1);
    check_val("rst_oe", int'(oe), 0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // mode 0: streaming, 1: 5-cycle stall on window (1,0), 2: valid every other cycle, 3: random
  task automatic run_frame(input int mode, input int stop_pix);
    int  f0, stall_left;
    bit  stalled, v, r;
    f0 = frames; stall_left = 0; stalled = 0;
    for (int i = 0; i < 3000; i++) begin
      if (stop_pix >= 0 && pix == stop_pix) return;
      v = 1'b1; r = 1'b1;
      case (mode)
        1: begin
          if (!stalled && q_x.size() > 0 && q_x[0] == 1 && q_y[0] == 0) begin
            stall_left = 5; stalled = 1;
          end
          if (stall_left > 0) begin
            r = 1'b0; stall_left--;
          end
        end
        2: v = (i % 2 == 0);
        3: begin
          v = ($urandom_range(0, 3) != 0);
          r = ($urandom_range(0, 2) != 0);
        end
        default: ;
      endcase
      cycle(v, r);
      if (frames != f0) return;
    end
    check_val("frame_timeout", 0, 1);
  endtask

  task automatic run_stride_frame();
    int  p2, nwin, ox, oy, done_seen;
    bit  exp_v;
    int  exp_x, exp_y;
    p2 = 0; nwin = 0; exp_v = 0; exp_x = 0; exp_y = 0; done_seen = 0;
    for (int i = 0; i < 80; i++) begin
      b_valid_in = (p2 < W2 * H2); b_ready_in = 1'b1;
      #1;
      check_val("s2_oe", int'(b_oe), int'(p2 < W2 * H2));
      check_val("s2_valid_out", int'(b_valid_out), int'(exp_v));
      if (exp_v) begin
        check_val("s2_out_x", int'(b_out_x), exp_x);
        check_val("s2_out_y", int'(b_out_y), exp_y);
        nwin++;
      end
      if (b_frame_done) done_seen++;
      exp_v = 0;
      if (p2 < W2 * H2) begin
        if (win_at(p2, W2, KK, S2, ox, oy)) begin
          exp_v = 1; exp_x = ox; exp_y = oy;
        end
        p2++;
      end
      @(negedge clk);
    end
    b_valid_in = 1'b0;
    check_val("s2_win_count", nwin, OW2 * OH2);
    check_val("s2_frame_done", done_seen, 1);
    #1;
    check_val("s2_pp_sel", int'(b_pp_sel), 1);
    check_val("s2_busy", int'(b_busy), 0);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
    b_valid_in = 1'b0; b_ready_in = 1'b0;
    frames = 0;
    model_clear();
    @(negedge clk);
    do_reset();
    run_frame(0, -1);
    run_frame(1, -1);
    run_frame(2, -1);
    run_frame(3, -1);
    run_frame(3, -1);
    check_val("frames_done", frames, 5);
    run_frame(0, 3 * W + 1);
    check_val("pre_reset_pp", int'(pp_sel), 1);
    do_reset();
    run_frame(0, -1);
    check_val("post_reset_frame", frames, 6);
    run_stride_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
